alu_cmd_sequencer: RTL

Command front-end for the ALU core. Collects an opcode byte and one or two operand bytes from a byte-wide valid/ready input stream, then presents a complete, stable command (op, A, B) to the ALU with a valid/ready handshake. It sits directly upstream of the ALU datapath, between the pin-level input bus and the ALU operand/opcode inputs. A timeout aborts partial commands.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_timer.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared types and constants for the ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OP_W_DEF   = 3;
   // The top bit of the opcode byte marks a single-operand command.
   localparam int UNARY_BIT  = DATA_W_DEF - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      GET_B = 2'd2,
      ISSUE = 2'd3
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_timer
// Brief    : Clearable idle-cycle counter; o_expire flags the TIMEOUT-th
//            consecutive counted cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_count,
   output logic o_expire
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign o_expire = i_count && (r_cnt == CNT_W'(TIMEOUT - 1));

   // Any cycle that is not counted breaks the run and restarts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_count || o_expire) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Assembles opcode + operand bytes into an ALU command with a
//            valid/ready handshake. Define ALU_SEQ_TIMEOUT_EN to abort stalled
//            partial commands after TIMEOUT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OP_W    = OP_W_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] cmd_a,
   output logic [DATA_W-1:0] cmd_b,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              busy,
   output logic              err_timeout
);

   seq_state_t r_state;
   seq_state_t w_next;
   logic       r_unary;
   logic       w_accept;
   logic       w_expire;

   assign in_ready  = (r_state != ISSUE);
   assign cmd_valid = (r_state == ISSUE);
   assign busy      = (r_state != IDLE);
   assign w_accept  = in_valid && in_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
   logic w_wait;
   logic r_err;

   assign w_wait = ((r_state == GET_A) || (r_state == GET_B)) && !w_accept;

   alu_seq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_count  (w_wait),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_expire;
      end
   end

   assign err_timeout = r_err;
`else
   assign w_expire    = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = GET_A;
         end
         GET_A: begin
            if (w_accept)      w_next = r_unary ? ISSUE : GET_B;
            else if (w_expire) w_next = IDLE;
         end
         GET_B: begin
            if (w_accept)      w_next = ISSUE;
            else if (w_expire) w_next = IDLE;
         end
         ISSUE: begin
            if (cmd_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Command fields only change on accepted bytes, so they stay put through
   // ISSUE and after the handshake or an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_op  <= '0;
         cmd_a   <= '0;
         cmd_b   <= '0;
         r_unary <= 1'b0;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               cmd_op  <= in_data[OP_W-1:0];
               r_unary <= in_data[DATA_W-1];
            end
            GET_A: begin
               cmd_a <= in_data;
               if (r_unary) cmd_b <= '0;
            end
            GET_B: begin
               cmd_b <= in_data;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
